vga_timing_detector: RTL and testbench
======================================

# vga_timing_detector

Receive-side counterpart of the VGA timing generator. Takes the h_sync, v_sync and display-enable stream of a VGA source on the same pixel clock. From it, recovers per-pixel column and row coordinates and measures line and frame geometry. Declares lock once the geometry is stable across consecutive frames. Sits at the input of capture and check logic: loopback test, video capture, or mode detection.

## Interface
- h_pol, 1: horizontal sync active level.
- v_pol, 0: vertical sync active level.
- lock_frames, 2: consecutive identical frames required for lock (1–15).
- pixel_clk  in  1: pixel clock; all logic on rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- h_sync  in  1: horizontal sync from source.
- v_sync  in  1: vertical sync from source.
- disp_ena  in  1: source display enable (1 = active pixel).
- column  out  11: pixel index within the active line; saturates at 2047.
- row  out  11: active-line index within the frame; saturates at 2047.
- pix_valid  out  1: column/row describe a live active pixel.
- line_start  out  1: one-cycle pulse on each h-assert edge.
- frame_start  out  1: one-cycle pulse on each v-assert edge.
- h_total  out  12: clocks between consecutive h-assert edges.
- h_active  out  12: disp_ena cycles in the last line that had any.
- v_total  out  12: lines between consecutive v-assert edges.
- v_active  out  12: lines containing disp_ena in the last complete frame.
- locked  out  1: geometry stable.
- timing_err  out  1: one-cycle pulse when geometry changes while locked.

## Operation
- Input stage: h_sync, v_sync and disp_ena are registered once (stage s1), then delayed once more (s2).
  - h-assert edge: s1 at h_pol and s2 not.
  - v-assert edge: the same rule on v_sync with v_pol.
  - DE rise / DE fall: disp_ena 0→1 / 1→0 between s2 and s1.
- Line counter hc (12 bit, saturating at 4095):
  - Resets to 1 on an h-assert edge; otherwise increments.
  - On each h-assert edge, h_total ← hc.
- DE counter (12 bit):
  - Counts s1 disp_ena cycles in the current line and clears on the h-assert edge.
  - On the h-assert edge, h_active ← the count, only if the count is nonzero.
- Line counter vc (12 bit, saturating) counts h-assert edges.
  - On a v-assert edge: v_total ← vc and v_active ← the active-line count.
  - After the latch, vc ← 1 if an h-assert edge coincides with the v-edge, else 0. A coincident line belongs to the new frame.
- Coordinates:
  - column clears on DE rise and increments each DE cycle.
  - row clears on the v-assert edge and increments on each DE fall.
  - pix_valid = s1 disp_ena, registered.
- Lock FSM, states SEARCH, MEASURE, LOCKED:
  - SEARCH: locked=0. On the first v-assert edge → MEASURE, clear match_cnt and the reference valid flag.
  - MEASURE: on each v-assert edge, compare the new {h_total, h_active, v_total, v_active} with the stored reference.
    - Equal, with reference valid: match_cnt+1. When match_cnt reaches lock_frames → LOCKED.
    - Not equal: store the new values as the reference, mark it valid, match_cnt=0.
  - LOCKED: locked=1.
    - Any h-assert edge where hc ≠ h_total: pulse timing_err, → MEASURE.
    - Any v-assert edge with a mismatch against the reference: pulse timing_err, → MEASURE.
    - In both cases store the new values as the reference and set match_cnt=0.
  - Any state: if hc saturates (4095 clocks without an h-assert edge) → SEARCH and locked=0. timing_err pulses if the FSM was LOCKED.
- Measurement outputs hold their last value when unlocked. They are meaningful only when locked=1.

## Timing
- Reset: every output is 0, the FSM is in SEARCH, and all counters and the reference are cleared.
- Latency:
  - column, row, pix_valid: 2 clocks from the disp_ena pin.
  - line_start, frame_start: 2 clocks from the sync pin edge.
  - h_total, h_active, v_total, v_active: update in the same cycle as line_start or frame_start.
  - locked, timing_err: assert the cycle after the deciding edge pulse.
- With lock_frames=L and a stable source, locked rises 1 clock after the (L+2)-th frame_start following reset.
- Reset asserted mid-frame returns all state to reset values immediately. After release, lock is reacquired per the rule above.

## Test plan
- Stable source: h pulse 4, bp 6, active 16, fp 2; v pulse 2, bp 3, active 8, fp 1; h_pol=1, v_pol=0. Expect:
  - h_total=28, h_active=16, v_total=14, v_active=8.
  - locked rises 1 clock after the 4th frame_start.
  - column runs 0..15 and row runs 0..7 with pix_valid.
- Locked, then one line stretched to 29 clocks: timing_err pulses once, locked falls. With the source restored, locked returns after the 3rd following frame_start.
- Syncs held inactive for 4096 clocks: FSM → SEARCH, locked=0, timing_err pulses once.
- v-assert edge coincident with an h-assert edge: v_total=14, vc restarts at 1, frame_start and line_start pulse in the same cycle.
- Active width 16 → 18 at a frame boundary: mismatch, no lock for 2 frames, then locked with h_active=18.
- reset_n pulsed low mid-line while locked: all outputs 0 asynchronously. After release, locked rises 1 clock after the 4th frame_start.

Source files
------------

// File: rtl/vga_timing_detector.sv
// Receive-side VGA timing recovery: pixel coordinates, line/frame geometry and
// a lock indicator that requires the geometry to repeat over consecutive frames.
module vga_timing_detector #(
    parameter bit          H_POL       = 1'b1,
    parameter bit          V_POL       = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        i_pixel_clk,
    input  logic        i_reset_n,
    input  logic        i_h_sync,
    input  logic        i_v_sync,
    input  logic        i_disp_ena,
    output logic [10:0] o_column,
    output logic [10:0] o_row,
    output logic        o_pix_valid,
    output logic        o_line_start,
    output logic        o_frame_start,
    output logic [11:0] o_h_total,
    output logic [11:0] o_h_active,
    output logic [11:0] o_v_total,
    output logic [11:0] o_v_active,
    output logic        o_locked,
    output logic        o_timing_err
);

    localparam logic [11:0] CNT_MAX     = 12'hFFF;
    localparam logic [10:0] COORD_MAX   = 11'h7FF;
    localparam logic [4:0]  LOCK_TARGET = 5'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic        r_hs1, r_hs2, r_vs1, r_vs2, r_de1, r_de2;
    logic        w_h_edge, w_v_edge, w_de_rise, w_de_fall;

    logic [11:0] r_hc, r_de_cnt, r_vc, r_vact_cnt;
    logic        w_hc_sat;

    logic [11:0] r_h_total, r_h_active, r_v_total, r_v_active;
    logic [10:0] r_column, r_row;
    logic        r_pix_valid, r_line_start, r_frame_start;

    state_t      r_state, w_state_next;
    logic [3:0]  r_match_cnt, w_match_next;
    logic [4:0]  w_match_inc;
    logic        r_ref_valid, w_ref_valid_next, w_ref_load;
    logic [11:0] r_ref_h_total, r_ref_h_active, r_ref_v_total, r_ref_v_active;
    logic        r_timing_err, w_err_next;
    logic        w_geom_eq, w_h_mismatch;

    // Two-stage input pipe; edges are judged between s1 (newer) and s2 (older).
    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hs1 <= 1'b0;
            r_hs2 <= 1'b0;
            r_vs1 <= 1'b0;
            r_vs2 <= 1'b0;
            r_de1 <= 1'b0;
            r_de2 <= 1'b0;
        end else begin
            r_hs1 <= i_h_sync;
            r_hs2 <= r_hs1;
            r_vs1 <= i_v_sync;
            r_vs2 <= r_vs1;
            r_de1 <= i_disp_ena;
            r_de2 <= r_de1;
        end
    end

    assign w_h_edge  = (r_hs1 == H_POL) && (r_hs2 != H_POL);
    assign w_v_edge  = (r_vs1 == V_POL) && (r_vs2 != V_POL);
    assign w_de_rise = r_de1 && !r_de2;
    assign w_de_fall = !r_de1 && r_de2;
    assign w_hc_sat  = (r_hc == CNT_MAX);

    // Horizontal measurement: clock count and DE count per line.
    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hc       <= '0;
            r_de_cnt   <= '0;
            r_h_total  <= '0;
            r_h_active <= '0;
        end else begin
            if (w_h_edge) begin
                r_hc      <= 12'd1;
                r_h_total <= r_hc;
                if (r_de_cnt != '0)
                    r_h_active <= r_de_cnt;
                r_de_cnt <= {11'd0, r_de1};
            end else begin
                if (!w_hc_sat)
                    r_hc <= r_hc + 12'd1;
                if (r_de1 && (r_de_cnt != CNT_MAX))
                    r_de_cnt <= r_de_cnt + 12'd1;
            end
        end
    end

    // A line whose h-edge coincides with the v-edge belongs to the new frame.
    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vc       <= '0;
            r_vact_cnt <= '0;
            r_v_total  <= '0;
            r_v_active <= '0;
        end else if (w_v_edge) begin
            r_v_total  <= r_vc;
            r_v_active <= r_vact_cnt;
            r_vc       <= w_h_edge ? 12'd1 : 12'd0;
            r_vact_cnt <= w_de_rise ? 12'd1 : 12'd0;
        end else begin
            if (w_h_edge && (r_vc != CNT_MAX))
                r_vc <= r_vc + 12'd1;
            if (w_de_rise && (r_vact_cnt != CNT_MAX))
                r_vact_cnt <= r_vact_cnt + 12'd1;
        end
    end

    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_column      <= '0;
            r_row         <= '0;
            r_pix_valid   <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_valid   <= r_de1;
            r_line_start  <= w_h_edge;
            r_frame_start <= w_v_edge;
            if (w_de_rise)
                r_column <= '0;
            else if (r_de1 && (r_column != COORD_MAX))
                r_column <= r_column + 11'd1;
            if (w_v_edge)
                r_row <= '0;
            else if (w_de_fall && (r_row != COORD_MAX))
                r_row <= r_row + 11'd1;
        end
    end

    // The FSM acts on the registered pulses so it sees freshly latched geometry.
    assign w_geom_eq = r_ref_valid &&
                       ({r_h_total, r_h_active, r_v_total, r_v_active} ==
                        {r_ref_h_total, r_ref_h_active, r_ref_v_total, r_ref_v_active});
    assign w_h_mismatch = (r_h_total != r_ref_h_total);
    assign w_match_inc  = {1'b0, r_match_cnt} + 5'd1;

    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_SEARCH;
            r_match_cnt    <= '0;
            r_ref_valid    <= 1'b0;
            r_ref_h_total  <= '0;
            r_ref_h_active <= '0;
            r_ref_v_total  <= '0;
            r_ref_v_active <= '0;
            r_timing_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_match_cnt  <= w_match_next;
            r_ref_valid  <= w_ref_valid_next;
            r_timing_err <= w_err_next;
            if (w_ref_load) begin
                r_ref_h_total  <= r_h_total;
                r_ref_h_active <= r_h_active;
                r_ref_v_total  <= r_v_total;
                r_ref_v_active <= r_v_active;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_match_next     = r_match_cnt;
        w_ref_valid_next = r_ref_valid;
        w_ref_load       = 1'b0;
        w_err_next       = 1'b0;
        if (w_hc_sat) begin
            w_state_next = ST_SEARCH;
            w_err_next   = (r_state == ST_LOCKED);
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    if (r_frame_start) begin
                        w_state_next     = ST_MEASURE;
                        w_match_next     = '0;
                        w_ref_valid_next = 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (r_frame_start) begin
                        if (w_geom_eq) begin
                            w_match_next = w_match_inc[3:0];
                            if (w_match_inc >= LOCK_TARGET)
                                w_state_next = ST_LOCKED;
                        end else begin
                            w_ref_load       = 1'b1;
                            w_ref_valid_next = 1'b1;
                            w_match_next     = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if ((r_line_start && w_h_mismatch) || (r_frame_start && !w_geom_eq)) begin
                        w_err_next       = 1'b1;
                        w_state_next     = ST_MEASURE;
                        w_ref_load       = 1'b1;
                        w_ref_valid_next = 1'b1;
                        w_match_next     = '0;
                    end
                end
                default: w_state_next = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        o_locked = (r_state == ST_LOCKED);
    end

    assign o_timing_err  = r_timing_err;
    assign o_column      = r_column;
    assign o_row         = r_row;
    assign o_pix_valid   = r_pix_valid;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_h_total     = r_h_total;
    assign o_h_active    = r_h_active;
    assign o_v_total     = r_v_total;
    assign o_v_active    = r_v_active;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench for vga_timing_detector: 28x14 test mode, lock, errors, resets.
module tb_vga_timing_detector;

    localparam bit H_POL       = 1'b1;
    localparam bit V_POL       = 1'b0;
    localparam int LOCK_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs = ~H_POL;
    logic        vs = ~V_POL;
    logic        de = 1'b0;
    logic [10:0] o_column, o_row;
    logic        o_pix_valid, o_line_start, o_frame_start;
    logic [11:0] o_h_total, o_h_active, o_v_total, o_v_active;
    logic        o_locked, o_timing_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_detector #(
        .H_POL(H_POL),
        .V_POL(V_POL),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .i_pixel_clk  (clk),
        .i_reset_n    (rst_n),
        .i_h_sync     (hs),
        .i_v_sync     (vs),
        .i_disp_ena   (de),
        .o_column     (o_column),
        .o_row        (o_row),
        .o_pix_valid  (o_pix_valid),
        .o_line_start (o_line_start),
        .o_frame_start(o_frame_start),
        .o_h_total    (o_h_total),
        .o_h_active   (o_h_active),
        .o_v_total    (o_v_total),
        .o_v_active   (o_v_active),
        .o_locked     (o_locked),
        .o_timing_err (o_timing_err)
    );

    // Event recorder sampled on the falling edge; cumulative counts only.
    int   fs_cnt = 0, ls_cnt = 0, both_cnt = 0, err_cnt = 0, err_fs = -100;
    int   lock_rise_fs = -100, lock_gap = -1, since_fs = 0;
    int   coord_bad = 0, pix_cnt = 0, prev_col = 0, mon_row = 0;
    int   fr_max_col = 0, fr_max_row = 0, last_max_col = 0, last_max_row = 0;
    logic prev_pv = 1'b0, prev_locked = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pv     <= 1'b0;
            prev_locked <= 1'b0;
            mon_row     <= 0;
            since_fs    <= 0;
        end else begin
            fs_cnt   <= fs_cnt + int'(o_frame_start);
            ls_cnt   <= ls_cnt + int'(o_line_start);
            both_cnt <= both_cnt + int'(o_frame_start && o_line_start);
            since_fs <= o_frame_start ? 0 : since_fs + 1;
            if (o_locked && !prev_locked) begin
                lock_rise_fs <= fs_cnt + int'(o_frame_start);
                lock_gap     <= o_frame_start ? 0 : since_fs + 1;
            end
            if (o_timing_err) begin
                err_cnt <= err_cnt + 1;
                err_fs  <= fs_cnt + int'(o_frame_start);
            end
            if (o_pix_valid) begin
                if (int'(o_column) != (prev_pv ? prev_col + 1 : 0) || int'(o_row) != mon_row)
                    coord_bad <= coord_bad + 1;
                pix_cnt <= pix_cnt + 1;
            end
            if (o_frame_start)
                mon_row <= 0;
            else if (prev_pv && !o_pix_valid)
                mon_row <= mon_row + 1;
            if (o_frame_start) begin
                last_max_col <= fr_max_col;
                last_max_row <= fr_max_row;
                fr_max_col   <= 0;
                fr_max_row   <= 0;
            end else if (o_pix_valid) begin
                if (int'(o_column) > fr_max_col) fr_max_col <= int'(o_column);
                if (int'(o_row) > fr_max_row) fr_max_row <= int'(o_row);
            end
            prev_pv     <= o_pix_valid;
            prev_col    <= int'(o_column);
            prev_locked <= o_locked;
        end
    end

    task automatic drive_cycle(input logic h, input logic v, input logic d);
        @(posedge clk);
        #1;
        hs = h;
        vs = v;
        de = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(~H_POL, ~V_POL, 1'b0);
    endtask

    // One 28-clock line (plus extra): sync 4, back porch bp, active aw, rest front porch.
    task automatic gen_line(input bit vsa, input bit act, input int aw, input int bp, input int extra);
        for (int c = 0; c < 28 + extra; c++)
            drive_cycle((c < 4) ? H_POL : ~H_POL, vsa ? V_POL : ~V_POL,
                        act && (c >= 4 + bp) && (c < 4 + bp + aw));
    endtask

    // 14-line frame: v pulse 2, back porch 3, active 8, front porch 1.
    task automatic gen_frame(input int aw, input int bp, input int stretch);
        for (int l = 0; l < 14; l++)
            gen_line(l < 2, (l >= 5) && (l < 13), aw, bp, (l == stretch) ? 1 : 0);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_column, o_row, o_pix_valid, o_line_start, o_frame_start} !== 25'd0) begin
            errors++;
            $display("FAIL reset_coords: got %h expected 0", {o_column, o_row, o_pix_valid, o_line_start, o_frame_start});
        end
        checks++;
        if ({o_h_total, o_h_active, o_v_total, o_v_active} !== 48'd0) begin
            errors++;
            $display("FAIL reset_geom: got %h expected 0", {o_h_total, o_h_active, o_v_total, o_v_active});
        end
        checks++;
        if ({o_locked, o_timing_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00", {o_locked, o_timing_err});
        end
        rst_n = 1'b1;
        idle(4);
        $display("test_reset done");
    endtask

    task automatic test_lock;
        int fs_b, err_b, cb, pb;
        fs_b = fs_cnt; err_b = err_cnt; cb = coord_bad; pb = pix_cnt;
        repeat (5) gen_frame(16, 6, -1);
        checks++;
        if (lock_rise_fs - fs_b != 4) begin
            errors++;
            $display("FAIL lock_frame: got %0d expected 4", lock_rise_fs - fs_b);
        end
        checks++;
        if (lock_gap != 1) begin
            errors++;
            $display("FAIL lock_gap: got %0d expected 1", lock_gap);
        end
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_level: got %b expected 1", o_locked);
        end
        checks++;
        if (err_cnt - err_b != 0) begin
            errors++;
            $display("FAIL lock_no_err: got %0d expected 0", err_cnt - err_b);
        end
        checks++;
        if (o_h_total !== 12'd28) begin
            errors++;
            $display("FAIL h_total: got %0d expected 28", o_h_total);
        end
        checks++;
        if (o_h_active !== 12'd16) begin
            errors++;
            $display("FAIL h_active: got %0d expected 16", o_h_active);
        end
        checks++;
        if (o_v_total !== 12'd14) begin
            errors++;
            $display("FAIL v_total: got %0d expected 14", o_v_total);
        end
        checks++;
        if (o_v_active !== 12'd8) begin
            errors++;
            $display("FAIL v_active: got %0d expected 8", o_v_active);
        end
        checks++;
        if (coord_bad - cb != 0) begin
            errors++;
            $display("FAIL coord_seq: got %0d bad pixels expected 0", coord_bad - cb);
        end
        checks++;
        if (pix_cnt - pb != 640) begin
            errors++;
            $display("FAIL pix_count: got %0d expected 640", pix_cnt - pb);
        end
        checks++;
        if (last_max_col != 15 || last_max_row != 7) begin
            errors++;
            $display("FAIL coord_max: got col %0d row %0d expected col 15 row 7", last_max_col, last_max_row);
        end
        $display("test_lock done: h_total=%0d v_total=%0d locked=%b", o_h_total, o_v_total, o_locked);
    endtask

    task automatic test_coincident;
        int fs_b, ls_b, both_b;
        fs_b = fs_cnt; ls_b = ls_cnt; both_b = both_cnt;
        gen_frame(16, 6, -1);
        checks++;
        if (fs_cnt - fs_b != 1 || both_cnt - both_b != 1) begin
            errors++;
            $display("FAIL coincident_pulse: got fs %0d both %0d expected 1 1", fs_cnt - fs_b, both_cnt - both_b);
        end
        checks++;
        if (ls_cnt - ls_b != 14) begin
            errors++;
            $display("FAIL line_starts: got %0d expected 14", ls_cnt - ls_b);
        end
        checks++;
        if (o_v_total !== 12'd14) begin
            errors++;
            $display("FAIL coincident_v_total: got %0d expected 14", o_v_total);
        end
        checks++;
        if (o_row !== 11'd8 || o_column !== 11'd15) begin
            errors++;
            $display("FAIL frame_end_coords: got row %0d col %0d expected row 8 col 15", o_row, o_column);
        end
        $display("test_coincident done: v_total=%0d", o_v_total);
    endtask

    task automatic test_stretch;
        int fs_b, err_b;
        fs_b = fs_cnt; err_b = err_cnt;
        gen_frame(16, 6, 6);
        checks++;
        if (err_cnt - err_b != 1 || err_fs - fs_b != 1) begin
            errors++;
            $display("FAIL stretch_err: got count %0d at frame %0d expected 1 at 1", err_cnt - err_b, err_fs - fs_b);
        end
        checks++;
        if (o_locked !== 1'b0) begin
            errors++;
            $display("FAIL stretch_unlock: got %b expected 0", o_locked);
        end
        repeat (3) gen_frame(16, 6, -1);
        checks++;
        if (lock_rise_fs - fs_b != 4 || o_locked !== 1'b1) begin
            errors++;
            $display("FAIL stretch_relock: got frame %0d locked %b expected 4 1", lock_rise_fs - fs_b, o_locked);
        end
        checks++;
        if (err_cnt - err_b != 1 || o_h_total !== 12'd28) begin
            errors++;
            $display("FAIL stretch_after: got errs %0d h_total %0d expected 1 28", err_cnt - err_b, o_h_total);
        end
        $display("test_stretch done: locked=%b", o_locked);
    endtask

    task automatic test_width;
        int fs_b, err_b, cb;
        fs_b = fs_cnt; err_b = err_cnt; cb = coord_bad;
        repeat (4) gen_frame(18, 5, -1);
        checks++;
        if (err_cnt - err_b != 1 || err_fs - fs_b != 2) begin
            errors++;
            $display("FAIL width_err: got count %0d at frame %0d expected 1 at 2", err_cnt - err_b, err_fs - fs_b);
        end
        checks++;
        if (lock_rise_fs - fs_b != 4 || o_locked !== 1'b1) begin
            errors++;
            $display("FAIL width_relock: got frame %0d locked %b expected 4 1", lock_rise_fs - fs_b, o_locked);
        end
        checks++;
        if (o_h_active !== 12'd18 || o_h_total !== 12'd28) begin
            errors++;
            $display("FAIL width_geom: got h_active %0d h_total %0d expected 18 28", o_h_active, o_h_total);
        end
        checks++;
        if (last_max_col != 17 || coord_bad - cb != 0) begin
            errors++;
            $display("FAIL width_coords: got max col %0d bad %0d expected 17 0", last_max_col, coord_bad - cb);
        end
        $display("test_width done: h_active=%0d", o_h_active);
    endtask

    task automatic test_saturation;
        int fs_b, err_b;
        err_b = err_cnt;
        idle(3000);
        checks++;
        if (o_locked !== 1'b1 || err_cnt - err_b != 0) begin
            errors++;
            $display("FAIL sat_early: got locked %b errs %0d expected 1 0", o_locked, err_cnt - err_b);
        end
        idle(1200);
        checks++;
        if (o_locked !== 1'b0 || err_cnt - err_b != 1) begin
            errors++;
            $display("FAIL sat_drop: got locked %b errs %0d expected 0 1", o_locked, err_cnt - err_b);
        end
        fs_b = fs_cnt;
        repeat (5) gen_frame(16, 6, -1);
        checks++;
        if (lock_rise_fs - fs_b != 4 || o_locked !== 1'b1 || err_cnt - err_b != 1) begin
            errors++;
            $display("FAIL sat_relock: got frame %0d locked %b errs %0d expected 4 1 1",
                     lock_rise_fs - fs_b, o_locked, err_cnt - err_b);
        end
        $display("test_saturation done: locked=%b", o_locked);
    endtask

    task automatic test_reset_midframe;
        int fs_b;
        for (int l = 0; l < 6; l++) gen_line(l < 2, l >= 5, 16, 6, 0);
        for (int c = 0; c < 14; c++) drive_cycle((c < 4) ? H_POL : ~H_POL, ~V_POL, c >= 10);
        checks++;
        if (o_locked !== 1'b1 || o_pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got locked %b pix_valid %b expected 1 1", o_locked, o_pix_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_column, o_row, o_pix_valid, o_line_start, o_frame_start, o_h_total, o_h_active,
             o_v_total, o_v_active, o_locked, o_timing_err} !== 75'd0) begin
            errors++;
            $display("FAIL midreset_zero: got %h expected 0",
                     {o_column, o_row, o_pix_valid, o_line_start, o_frame_start, o_h_total,
                      o_h_active, o_v_total, o_v_active, o_locked, o_timing_err});
        end
        idle(3);
        rst_n = 1'b1;
        idle(4);
        fs_b = fs_cnt;
        repeat (5) gen_frame(16, 6, -1);
        checks++;
        if (lock_rise_fs - fs_b != 4 || lock_gap != 1 || o_locked !== 1'b1) begin
            errors++;
            $display("FAIL midreset_relock: got frame %0d gap %0d locked %b expected 4 1 1",
                     lock_rise_fs - fs_b, lock_gap, o_locked);
        end
        checks++;
        if (o_v_total !== 12'd14 || o_h_total !== 12'd28) begin
            errors++;
            $display("FAIL midreset_geom: got v_total %0d h_total %0d expected 14 28", o_v_total, o_h_total);
        end
        $display("test_reset_midframe done: locked=%b", o_locked);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_coincident();
        test_stretch();
        test_width();
        test_saturation();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
